exception_unit: RTL and testbench

- Consumes the per-unit exception descriptor codes from the eBPF core: ALU, register file, control, data memory and instruction memory.
- Prioritises simultaneous exceptions and latches the first one as a global class/descriptor pair with the faulting PC.
- Halts the core and reports the exception to the host through a valid/ack interrupt handshake.
- Sits between the core's execution units and the host-facing control/status logic.

---
 rtl/exception_unit_pkg.sv | 44 ++++
 rtl/exception_priority_encoder.sv | 38 +++
 rtl/exception_unit.sv | 132 +++++++++++++
 tb/tb_exception_unit.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exception_unit_pkg.sv
// Shared types and constants for the exception unit: FSM states, global
// exception class codes, per-unit descriptor codes and priority ranks.
package exception_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        TRAP = 2'd2
    } exc_state_t;

    // Global exception class codes reported to the host.
    localparam logic [2:0] CLASS_NONE = 3'b000;
    localparam logic [2:0] CLASS_ALU  = 3'b001;
    localparam logic [2:0] CLASS_REG  = 3'b010;
    localparam logic [2:0] CLASS_CTRL = 3'b011;
    localparam logic [2:0] CLASS_DMEM = 3'b101;
    localparam logic [2:0] CLASS_IMEM = 3'b110;

    // Per-unit descriptor codes; 00 always means "no exception".
    localparam logic [1:0] DESC_NONE = 2'b00;
    localparam logic [1:0] CTRL_EXIT = 2'b11;

    // Priority ranks, 0 = highest priority.
    localparam int             NUM_UNITS = 5;
    localparam int             RANK_W    = 3;
    localparam logic [RANK_W-1:0] PRIO_IMEM = 3'd0;
    localparam logic [RANK_W-1:0] PRIO_CTRL = 3'd1;
    localparam logic [RANK_W-1:0] PRIO_REG  = 3'd2;
    localparam logic [RANK_W-1:0] PRIO_ALU  = 3'd3;
    localparam logic [RANK_W-1:0] PRIO_DMEM = 3'd4;

    // Maps a priority rank to the class code of the unit holding it.
    function automatic logic [2:0] rank_class(input logic [RANK_W-1:0] rank);
        case (rank)
            PRIO_IMEM: rank_class = CLASS_IMEM;
            PRIO_CTRL: rank_class = CLASS_CTRL;
            PRIO_REG:  rank_class = CLASS_REG;
            PRIO_ALU:  rank_class = CLASS_ALU;
            PRIO_DMEM: rank_class = CLASS_DMEM;
            default:   rank_class = CLASS_NONE;
        endcase
    endfunction

endpackage

// File: rtl/exception_priority_encoder.sv
// Combinational fixed-priority selection among the five per-unit exception
// descriptors: imem > ctrl > reg > alu > dmem.
module exception_priority_encoder
    import exception_unit_pkg::*;
(
    input  logic [1:0] i_alu_exc,
    input  logic [1:0] i_reg_exc,
    input  logic [1:0] i_ctrl_exc,
    input  logic [1:0] i_dmem_exc,
    input  logic [1:0] i_imem_exc,
    output logic       o_any_exc,
    output logic [2:0] o_class,
    output logic [1:0] o_descriptor
);

    logic [1:0] w_desc [NUM_UNITS];

    // Arrange descriptors by rank, then scan lowest to highest priority so
    // the highest-priority nonzero descriptor is the last one written.
    always_comb begin
        w_desc[PRIO_IMEM] = i_imem_exc;
        w_desc[PRIO_CTRL] = i_ctrl_exc;
        w_desc[PRIO_REG]  = i_reg_exc;
        w_desc[PRIO_ALU]  = i_alu_exc;
        w_desc[PRIO_DMEM] = i_dmem_exc;
        o_any_exc    = 1'b0;
        o_class      = CLASS_NONE;
        o_descriptor = DESC_NONE;
        for (int i = NUM_UNITS - 1; i >= 0; i--) begin
            if (w_desc[i[RANK_W-1:0]] != DESC_NONE) begin
                o_any_exc    = 1'b1;
                o_class      = rank_class(i[RANK_W-1:0]);
                o_descriptor = w_desc[i[RANK_W-1:0]];
            end
        end
    end

endmodule

// File: rtl/exception_unit.sv
// Exception unit: runs the core on start, latches the first (highest
// priority) exception with its PC, halts the core and raises an interrupt
// to the host that stays pending until acknowledged.
module exception_unit
    import exception_unit_pkg::*;
#(
    parameter int PC_WIDTH        = 12,
    parameter int CYCLE_CNT_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [PC_WIDTH-1:0]        pc,
    input  logic [1:0]                 alu_exc,
    input  logic [1:0]                 reg_exc,
    input  logic [1:0]                 ctrl_exc,
    input  logic [1:0]                 dmem_exc,
    input  logic [1:0]                 imem_exc,
    input  logic                       irq_ack,
    output logic                       running,
    output logic                       halt,
    output logic                       irq_valid,
    output logic [2:0]                 exc_class,
    output logic [1:0]                 exc_descriptor,
    output logic [PC_WIDTH-1:0]        exc_pc,
    output logic                       exit_ok,
    output logic [CYCLE_CNT_WIDTH-1:0] cycle_count
);

    exc_state_t                 r_state;
    exc_state_t                 w_next_state;
    logic                       r_running;
    logic                       r_halt;
    logic                       r_irq_valid;
    logic [2:0]                 r_exc_class;
    logic [1:0]                 r_exc_desc;
    logic [PC_WIDTH-1:0]        r_exc_pc;
    logic                       r_exit_ok;
    logic [CYCLE_CNT_WIDTH-1:0] r_cycle_count;

    logic                       w_any_exc;
    logic [2:0]                 w_class;
    logic [1:0]                 w_desc;

    // Counter sticks at all-ones instead of wrapping.
    function automatic logic [CYCLE_CNT_WIDTH-1:0] sat_inc(
        input logic [CYCLE_CNT_WIDTH-1:0] value
    );
        if (&value) begin
            sat_inc = value;
        end else begin
            sat_inc = value + CYCLE_CNT_WIDTH'(1);
        end
    endfunction

    exception_priority_encoder u_prio (
        .i_alu_exc    (alu_exc),
        .i_reg_exc    (reg_exc),
        .i_ctrl_exc   (ctrl_exc),
        .i_dmem_exc   (dmem_exc),
        .i_imem_exc   (imem_exc),
        .o_any_exc    (w_any_exc),
        .o_class      (w_class),
        .o_descriptor (w_desc)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: descriptors only matter in RUN, start only in IDLE,
    // acknowledge only in TRAP.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start) w_next_state = RUN;
            RUN:     if (w_any_exc) w_next_state = TRAP;
            TRAP:    if (r_irq_valid && irq_ack) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Registered outputs and exception record; status flags follow the
    // state being entered so they are valid on the same edge as the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_running     <= 1'b0;
            r_halt        <= 1'b1;
            r_irq_valid   <= 1'b0;
            r_exc_class   <= CLASS_NONE;
            r_exc_desc    <= DESC_NONE;
            r_exc_pc      <= '0;
            r_exit_ok     <= 1'b0;
            r_cycle_count <= '0;
        end else begin
            r_running   <= (w_next_state == RUN);
            r_halt      <= (w_next_state != RUN);
            r_irq_valid <= (w_next_state == TRAP);
            if (r_state == IDLE && start) begin
                r_exc_class   <= CLASS_NONE;
                r_exc_desc    <= DESC_NONE;
                r_exc_pc      <= '0;
                r_exit_ok     <= 1'b0;
                r_cycle_count <= '0;
            end
            if (r_state == RUN) begin
                r_cycle_count <= sat_inc(r_cycle_count);
                if (w_any_exc) begin
                    r_exc_class <= w_class;
                    r_exc_desc  <= w_desc;
                    r_exc_pc    <= pc;
                    r_exit_ok   <= (w_class == CLASS_CTRL) && (w_desc == CTRL_EXIT);
                end
            end
        end
    end

    assign running        = r_running;
    assign halt           = r_halt;
    assign irq_valid      = r_irq_valid;
    assign exc_class      = r_exc_class;
    assign exc_descriptor = r_exc_desc;
    assign exc_pc         = r_exc_pc;
    assign exit_ok        = r_exit_ok;
    assign cycle_count    = r_cycle_count;

endmodule

// File: tb/tb_exception_unit.sv
// Scoreboard bench for exception_unit: every driven cycle pushes the
// predicted outputs, which are popped and compared after the clock edge.
module tb_exception_unit;

    logic        clk = 1'b0;
    logic        rst_n, start, irq_ack;
    logic [11:0] pc;
    logic [1:0]  alu_exc, reg_exc, ctrl_exc, dmem_exc, imem_exc;

    logic        running, halt, irq_valid, exit_ok;
    logic [2:0]  exc_class;
    logic [1:0]  exc_descriptor;
    logic [11:0] exc_pc;
    logic [31:0] cycle_count;

    logic        sat_running, sat_halt, sat_irq_valid, sat_exit_ok;
    logic [2:0]  sat_class;
    logic [1:0]  sat_desc;
    logic [11:0] sat_pc;
    logic [3:0]  sat_count;

    always #5 clk = ~clk;

    exception_unit #(.PC_WIDTH(12), .CYCLE_CNT_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pc(pc),
        .alu_exc(alu_exc), .reg_exc(reg_exc), .ctrl_exc(ctrl_exc),
        .dmem_exc(dmem_exc), .imem_exc(imem_exc), .irq_ack(irq_ack),
        .running(running), .halt(halt), .irq_valid(irq_valid),
        .exc_class(exc_class), .exc_descriptor(exc_descriptor),
        .exc_pc(exc_pc), .exit_ok(exit_ok), .cycle_count(cycle_count)
    );

    exception_unit #(.PC_WIDTH(12), .CYCLE_CNT_WIDTH(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .pc(pc),
        .alu_exc(alu_exc), .reg_exc(reg_exc), .ctrl_exc(ctrl_exc),
        .dmem_exc(dmem_exc), .imem_exc(imem_exc), .irq_ack(irq_ack),
        .running(sat_running), .halt(sat_halt), .irq_valid(sat_irq_valid),
        .exc_class(sat_class), .exc_descriptor(sat_desc),
        .exc_pc(sat_pc), .exit_ok(sat_exit_ok), .cycle_count(sat_count)
    );

    typedef struct packed {
        logic        running;
        logic        halt;
        logic        irqv;
        logic [2:0]  cls;
        logic [1:0]  desc;
        logic [11:0] pc;
        logic        exit_ok;
        logic [31:0] cnt;
    } obs_t;

    obs_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model state: 0 idle, 1 run, 2 trap.
    int   m_state = 0;
    obs_t m       = '0;

    function automatic obs_t observe();
        return {running, halt, irq_valid, exc_class, exc_descriptor, exc_pc, exit_ok, cycle_count};
    endfunction

    // Drive one cycle of stimulus, predict the outputs after the edge and
    // push the prediction, then advance to just after the edge.
    task automatic drive(input logic r, input logic s, input logic [11:0] p,
                         input logic [1:0] a, input logic [1:0] rg, input logic [1:0] c,
                         input logic [1:0] d, input logic [1:0] im, input logic ack);
        logic       any;
        logic [2:0] cls;
        logic [1:0] dsc;
        rst_n = r; start = s; pc = p; irq_ack = ack;
        alu_exc = a; reg_exc = rg; ctrl_exc = c; dmem_exc = d; imem_exc = im;
        any = 1'b1;
        if (im != 2'b00)      begin cls = 3'b110; dsc = im; end
        else if (c != 2'b00)  begin cls = 3'b011; dsc = c;  end
        else if (rg != 2'b00) begin cls = 3'b010; dsc = rg; end
        else if (a != 2'b00)  begin cls = 3'b001; dsc = a;  end
        else if (d != 2'b00)  begin cls = 3'b101; dsc = d;  end
        else begin any = 1'b0; cls = 3'b000; dsc = 2'b00; end
        if (!r) begin
            m_state = 0; m = '0; m.halt = 1'b1;
        end else begin
            case (m_state)
                0: if (s) begin
                    m_state = 1; m.running = 1'b1; m.halt = 1'b0;
                    m.cls = 3'b000; m.desc = 2'b00; m.pc = 12'h000; m.exit_ok = 1'b0; m.cnt = 32'd0;
                end
                1: begin
                    if (m.cnt != 32'hFFFF_FFFF) m.cnt = m.cnt + 32'd1;
                    if (any) begin
                        m_state = 2; m.running = 1'b0; m.halt = 1'b1; m.irqv = 1'b1;
                        m.cls = cls; m.desc = dsc; m.pc = p;
                        m.exit_ok = (cls == 3'b011) && (dsc == 2'b11);
                    end
                end
                default: if (ack) begin
                    m_state = 0; m.irqv = 1'b0;
                end
            endcase
        end
        exp_q.push_back(m);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t e, a;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 12'h000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
            e = exp_q.pop_front(); a = observe(); checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL reset step %0d actual=%h required=%h", i, a, e);
            end
        end
        checks++;
        if ({halt, running, irq_valid, exc_class, exc_descriptor, cycle_count} !== {1'b1, 1'b0, 1'b0, 3'b000, 2'b00, 32'd0}) begin
            failures++;
            $display("FAIL reset_values actual=%b/%b/%b/%b/%b/%0d required=1/0/0/000/00/0",
                     halt, running, irq_valid, exc_class, exc_descriptor, cycle_count);
        end
    endtask

    task automatic test_exit();
        obs_t e, a;
        for (int i = 0; i < 8; i++) begin
            case (i)
                0:       drive(1'b1, 1'b1, 12'h000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
                6:       drive(1'b1, 1'b0, 12'h010, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 1'b0);
                7:       drive(1'b1, 1'b0, 12'h011, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
                default: drive(1'b1, 1'b0, 12'(i), 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
            endcase
            e = exp_q.pop_front(); a = observe(); checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL exit step %0d actual=%h required=%h", i, a, e);
            end
            if (i == 6) begin
                checks++;
                if ({exc_class, exc_descriptor, exc_pc, exit_ok, irq_valid, halt, cycle_count} !==
                    {3'b011, 2'b11, 12'h010, 1'b1, 1'b1, 1'b1, 32'd6}) begin
                    failures++;
                    $display("FAIL exit_record actual=%b/%b/%h/%b/%b/%b/%0d required=011/11/010/1/1/1/6",
                             exc_class, exc_descriptor, exc_pc, exit_ok, irq_valid, halt, cycle_count);
                end
            end
        end
    endtask

    task automatic test_trap_freeze();
        obs_t e, a;
        for (int i = 0; i < 11; i++) begin
            case (i)
                0:  drive(1'b1, 1'b1, 12'h000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
                1:  drive(1'b1, 1'b0, 12'h0AA, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
                2:  drive(1'b1, 1'b0, 12'h0AB, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
                3, 4, 6:
                    drive(1'b1, 1'b0, 12'(i * 16), 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0);
                5:  drive(1'b1, 1'b1, 12'h3FF, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0);
                7:  drive(1'b1, 1'b0, 12'h000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
                8:  drive(1'b1, 1'b0, 12'h000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
                9:  drive(1'b1, 1'b0, 12'h000, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
                default: drive(1'b1, 1'b1, 12'h000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
            endcase
            e = exp_q.pop_front(); a = observe(); checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL freeze step %0d actual=%h required=%h", i, a, e);
            end
            if (i == 6) begin
                checks++;
                if ({exc_class, exc_descriptor, exc_pc, irq_valid} !== {3'b001, 2'b01, 12'h0AB, 1'b1}) begin
                    failures++;
                    $display("FAIL freeze_record actual=%b/%b/%h/%b required=001/01/0ab/1",
                             exc_class, exc_descriptor, exc_pc, irq_valid);
                end
            end
            if (i == 8) begin
                checks++;
                if ({irq_valid, halt, exc_class, exc_descriptor} !== {1'b0, 1'b1, 3'b001, 2'b01}) begin
                    failures++;
                    $display("FAIL ack_readable actual=%b/%b/%b/%b required=0/1/001/01",
                             irq_valid, halt, exc_class, exc_descriptor);
                end
            end
            if (i == 10) begin
                checks++;
                if ({running, exc_class, exc_descriptor, exc_pc, cycle_count} !== {1'b1, 3'b000, 2'b00, 12'h000, 32'd0}) begin
                    failures++;
                    $display("FAIL start_clears actual=%b/%b/%b/%h/%0d required=1/000/00/000/0",
                             running, exc_class, exc_descriptor, exc_pc, cycle_count);
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        obs_t e, a;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: drive(1'b1, 1'b0, 12'h021, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
                1: drive(1'b1, 1'b1, 12'h022, 2'b01, 2'b00, 2'b00, 2'b01, 2'b10, 1'b0);
                default: drive(1'b1, 1'b0, 12'h000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
            endcase
            e = exp_q.pop_front(); a = observe(); checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL simultaneous step %0d actual=%h required=%h", i, a, e);
            end
            if (i == 1) begin
                checks++;
                if ({exc_class, exc_descriptor, exit_ok, exc_pc} !== {3'b110, 2'b10, 1'b0, 12'h022}) begin
                    failures++;
                    $display("FAIL simultaneous_record actual=%b/%b/%b/%h required=110/10/0/022",
                             exc_class, exc_descriptor, exit_ok, exc_pc);
                end
            end
        end
    endtask

    task automatic test_saturation();
        obs_t e, a;
        for (int k = 0; k <= 22; k++) begin
            if (k == 0)       drive(1'b1, 1'b1, 12'h000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
            else if (k == 21) drive(1'b1, 1'b0, 12'h055, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 1'b0);
            else if (k == 22) drive(1'b1, 1'b0, 12'h000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
            else              drive(1'b1, 1'b0, 12'(k), 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
            e = exp_q.pop_front(); a = observe(); checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL saturation step %0d actual=%h required=%h", k, a, e);
            end
            checks++;
            if ({sat_running, sat_halt, sat_irq_valid, sat_class, sat_desc, sat_pc, sat_exit_ok, sat_count} !==
                {e.running, e.halt, e.irqv, e.cls, e.desc, e.pc, e.exit_ok, 4'((k > 15) ? 15 : k)}) begin
                failures++;
                $display("FAIL sat_count step %0d actual=%0d required=%0d", k, sat_count, (k > 15) ? 15 : k);
            end
        end
    endtask

    task automatic test_reset_mid_trap();
        obs_t e, a;
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: drive(1'b1, 1'b1, 12'h000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
                1: drive(1'b1, 1'b0, 12'h077, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0);
                2: drive(1'b0, 1'b0, 12'h000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
                3: drive(1'b1, 1'b0, 12'h000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
                default: drive(1'b1, 1'b0, 12'h000, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
            endcase
            e = exp_q.pop_front(); a = observe(); checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL reset_mid_trap step %0d actual=%h required=%h", i, a, e);
            end
            if (i == 1) begin
                checks++;
                if ({exc_class, irq_valid, cycle_count} !== {3'b101, 1'b1, 32'd1}) begin
                    failures++;
                    $display("FAIL dmem_trap actual=%b/%b/%0d required=101/1/1", exc_class, irq_valid, cycle_count);
                end
            end
            if (i == 3) begin
                checks++;
                if ({halt, running, irq_valid, exc_class, exc_descriptor, exc_pc, exit_ok, cycle_count} !==
                    {1'b1, 1'b0, 1'b0, 3'b000, 2'b00, 12'h000, 1'b0, 32'd0}) begin
                    failures++;
                    $display("FAIL ack_after_reset actual=%b/%b/%b/%b/%b/%h/%b/%0d required=1/0/0/000/00/000/0/0",
                             halt, running, irq_valid, exc_class, exc_descriptor, exc_pc, exit_ok, cycle_count);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_exit();
        test_trap_freeze();
        test_simultaneous();
        test_saturation();
        test_reset_mid_trap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
